// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive/transmit blocks.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } ps2_rx_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioning: 2-flop synchronizer, FILTER_LEN-sample level filter
// and falling-edge detector on the filtered level.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  output logic fall_edge
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] sr_q;
  logic                  lvl_q;
  logic                  lvl_d;

  // Level only moves on a unanimous window, so short glitches never toggle it.
  always_comb begin
    lvl_d = lvl_q;
    if (&sr_q)      lvl_d = 1'b1;
    else if (~|sr_q) lvl_d = 1'b0;
  end

  assign fall_edge = lvl_q & ~lvl_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      sr_q   <= '1;
      lvl_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], ps2c};
      sr_q   <= {sr_q[FILTER_LEN-2:0], sync_q[1]};
      lvl_q  <= lvl_d;
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver with parity and framing checks.
// Define PS2_RX_TIMEOUT_EN to abort frames whose clock stalls for TIMEOUT_CYCLES.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_tick
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  function automatic logic parity_fail(input logic [PS2_FRAME_BITS-1:0] f);
    return ~^f[9:1];
  endfunction

  function automatic logic framing_fail(input logic [PS2_FRAME_BITS-1:0] f);
    return f[0] | ~f[10];
  endfunction

  ps2_rx_state_t             state_q;
  logic [PS2_FRAME_BITS-1:0] b_q, b_d;
  logic [3:0]                n_q;
  logic [1:0]                d_sync_q;
  logic [PS2_DATA_BITS-1:0]  dout_q;
  logic                      perr_q, ferr_q, done_q, tmo_tick_q;
  logic                      fall_edge;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .fall_edge (fall_edge)
  );

  // Bits arrive LSB first, so each new bit enters at the top and shifts right.
  assign b_d = {d_sync_q[1], b_q[PS2_FRAME_BITS-1:1]};

`ifdef PS2_RX_TIMEOUT_EN
  logic [TW-1:0] tmo_cnt_q;
  wire           tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || fall_edge || state_q != DPS) tmo_cnt_q <= '0;
    else                                      tmo_cnt_q <= tmo_cnt_q + TW'(1);
  end
`else
  wire  tmo_hit = 1'b0;
  logic unused_tmo;
  assign unused_tmo = ^TW'(TIMEOUT_CYCLES - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      d_sync_q   <= '1;
      b_q        <= '0;
      n_q        <= '0;
      dout_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_tick_q <= 1'b0;
    end else begin
      d_sync_q   <= {d_sync_q[0], ps2d};
      done_q     <= 1'b0;
      tmo_tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall_edge && rx_en) begin
            b_q     <= b_d;
            n_q     <= 4'd9;
            state_q <= DPS;
          end
        end
        DPS: begin
          if (fall_edge) begin
            b_q <= b_d;
            if (n_q == 4'd0) begin
              // Outputs are captured here so they appear in the LOAD cycle.
              state_q <= LOAD;
              done_q  <= 1'b1;
              dout_q  <= b_d[8:1];
              perr_q  <= parity_fail(b_d);
              ferr_q  <= framing_fail(b_d);
            end else begin
              n_q <= n_q - 4'd1;
            end
          end else if (tmo_hit) begin
            state_q    <= IDLE;
            tmo_tick_q <= 1'b1;
          end
        end
        LOAD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign timeout_tick = tmo_tick_q;

endmodule
